// File: rtl/lut_net_pkg.sv
// Shared types and constants for the LUT-network datapath: default feature
// geometry, the input packer state encoding and a reference quantizer.
package lut_net_pkg;

  localparam int N_FEAT = 16;
  localparam int FEAT_W = 8;
  localparam int Q_W    = 4;
  localparam int ADDR_W = N_FEAT * Q_W;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    FULL_WAIT = 2'd1,
    DROP      = 2'd2
  } state_t;

  // Bias, arithmetic shift and clamp to [0, 2^Q_W-1] at the default widths.
  // The sum is formed two bits wider than the feature so it cannot overflow.
  function automatic logic [Q_W-1:0] quantize(input logic [FEAT_W-1:0] d,
                                              input int shift,
                                              input int bias);
    logic signed [FEAT_W+1:0] sum;
    logic signed [FEAT_W+1:0] shf;
    logic signed [FEAT_W+1:0] q_max;
    q_max = (FEAT_W+2)'((1 << Q_W) - 1);
    sum   = $signed({{2{d[FEAT_W-1]}}, d}) + (FEAT_W+2)'(bias);
    shf   = sum >>> shift;
    if (shf[FEAT_W+1])    quantize = '0;
    else if (shf > q_max) quantize = '1;
    else                  quantize = shf[Q_W-1:0];
  endfunction

endpackage

// File: rtl/input_quant_packer_quantizer.sv
// Combinational feature quantizer: q = clamp((d + BIAS) >>> SHIFT, 0, 2^Q_W-1),
// evaluated at FEAT_W+2 signed bits so the biased sum never wraps.
module feat_quantizer #(
  parameter int FEAT_W = 8,
  parameter int Q_W    = 4,
  parameter int SHIFT  = 4,
  parameter int BIAS   = 128
) (
  input  logic [FEAT_W-1:0] data,
  output logic [Q_W-1:0]    q
);

  localparam logic signed [FEAT_W+1:0] Q_MAX  = (FEAT_W+2)'((1 << Q_W) - 1);
  localparam logic signed [FEAT_W+1:0] BIAS_V = (FEAT_W+2)'(BIAS);

  logic signed [FEAT_W+1:0] sum;
  logic signed [FEAT_W+1:0] shf;

  // Sign-extend, bias, shift, then saturate at both ends of the code range.
  always_comb begin
    sum = $signed({{2{data[FEAT_W-1]}}, data}) + BIAS_V;
    shf = sum >>> SHIFT;
    if (shf[FEAT_W+1])    q = '0;
    else if (shf > Q_MAX) q = '1;
    else                  q = shf[Q_W-1:0];
  end

endmodule

// File: rtl/input_quant_packer.sv
// Streams signed raw features in, quantizes each one and packs N_FEAT codes
// into one address word for layer 0. Framing errors discard the partial
// vector and raise a sticky flag; a full vector waits in FULL_WAIT while the
// output register is still occupied.
module input_quant_packer
  import lut_net_pkg::*;
#(
  parameter int N_FEAT = lut_net_pkg::N_FEAT,
  parameter int FEAT_W = lut_net_pkg::FEAT_W,
  parameter int Q_W    = lut_net_pkg::Q_W,
  parameter int SHIFT  = 4,
  parameter int BIAS   = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [FEAT_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_FEAT*Q_W-1:0]   m_address,
  output logic                    frame_err
);

  localparam int VEC_W = N_FEAT * Q_W;
  localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] asm_q, asm_d, asm_filled;
  logic [VEC_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [Q_W-1:0]   q;
  logic             last_idx;
  logic             out_free;

  feat_quantizer #(
    .FEAT_W (FEAT_W),
    .Q_W    (Q_W),
    .SHIFT  (SHIFT),
    .BIAS   (BIAS)
  ) u_quant (
    .data (s_data),
    .q    (q)
  );

  assign last_idx = (cnt_q == LAST_IDX);
  // The output register can take a new vector if empty or draining this cycle.
  assign out_free = !valid_q || m_ready;

  // Next-state, datapath updates and input handshake for the packer FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    out_d      = out_q;
    valid_d    = valid_q && !m_ready;
    err_d      = err_q;
    s_ready    = 1'b0;
    asm_filled = asm_q;
    asm_filled[int'(cnt_q)*Q_W +: Q_W] = q;

    case (state_q)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (last_idx && s_last) begin
            cnt_d = '0;
            if (out_free) begin
              out_d   = asm_filled;
              valid_d = 1'b1;
              asm_d   = '0;
            end else begin
              asm_d   = asm_filled;
              state_d = FULL_WAIT;
            end
          end else if (s_last) begin
            err_d = 1'b1;
            cnt_d = '0;
            asm_d = '0;
          end else if (last_idx) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
            state_d = DROP;
          end else begin
            asm_d = asm_filled;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL_WAIT: begin
        if (out_free) begin
          out_d   = asm_q;
          valid_d = 1'b1;
          asm_d   = '0;
          state_d = FILL;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase

    // Nothing is accepted while reset is held.
    s_ready = s_ready && !rst;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Counter, assembly/output registers and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: the wide data registers are reset too, because the reset state
    // of m_address is observable downstream.
    if (rst) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // A held vector is withdrawn during reset so no transfer happens that cycle.
  assign m_valid   = valid_q && !rst;
  assign m_address = out_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_input_quant_packer.sv
// Directed bench for input_quant_packer: packing, saturation, back-pressure,
// framing errors and mid-vector reset, all with hand-computed vectors.
module tb_input_quant_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_address;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] outq[$];

  localparam logic [63:0] V_ZERO = 64'h8888_8888_8888_8888;
  localparam logic [63:0] V_POS  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] V_NEG  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] V_RAMP = 64'hFEDC_BA98_7654_3210;

  input_quant_packer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_address (m_address),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Record every output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_valid && m_ready) outq.push_back(m_address);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [7:0] start, input logic [7:0] step);
    for (int i = 0; i < 16; i++) beat(start + 8'(i) * step, i == 15);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    tick();
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_address", m_address, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", {63'd0, s_ready}, 64'd1);

    // Basic packing and latency, then three more vectors back to back.
    send_vec(8'h00, 8'h00);
    check("zero_latency_valid", {63'd0, m_valid}, 64'd1);
    check("zero_address", m_address, V_ZERO);
    check("zero_s_ready", {63'd0, s_ready}, 64'd1);
    send_vec(8'h7F, 8'h00);
    check("no_bubble_s_ready", {63'd0, s_ready}, 64'd1);
    send_vec(8'h80, 8'h00);
    send_vec(8'h80, 8'h10);
    tick(); tick();
    check("stream_count", 64'(outq.size()), 64'd4);
    check("stream_v0", outq.size() > 0 ? outq[0] : 'x, V_ZERO);
    check("stream_v1_sat_hi", outq.size() > 1 ? outq[1] : 'x, V_POS);
    check("stream_v2_sat_lo", outq.size() > 2 ? outq[2] : 'x, V_NEG);
    check("stream_v3_ramp", outq.size() > 3 ? outq[3] : 'x, V_RAMP);
    check("stream_idle_valid", {63'd0, m_valid}, 64'd0);

    // Back-pressure: two vectors with m_ready low.
    outq.delete();
    m_ready = 1'b0;
    send_vec(8'h00, 8'h00);
    check("bp_first_valid", {63'd0, m_valid}, 64'd1);
    send_vec(8'h80, 8'h10);
    check("bp_s_ready_drop", {63'd0, s_ready}, 64'd0);
    check("bp_held_addr", m_address, V_ZERO);
    tick(); tick(); tick();
    check("bp_still_held", m_address, V_ZERO);
    check("bp_still_valid", {63'd0, m_valid}, 64'd1);
    check("bp_still_stalled", {63'd0, s_ready}, 64'd0);
    m_ready = 1'b1;
    tick(); tick(); tick();
    check("bp_count", 64'(outq.size()), 64'd2);
    check("bp_order_first", outq.size() > 0 ? outq[0] : 'x, V_ZERO);
    check("bp_order_second", outq.size() > 1 ? outq[1] : 'x, V_RAMP);
    check("bp_drained_valid", {63'd0, m_valid}, 64'd0);
    check("bp_resume_s_ready", {63'd0, s_ready}, 64'd1);

    // Early s_last at index 5.
    outq.delete();
    for (int i = 0; i < 6; i++) beat(8'h7F, i == 5);
    tick();
    check("early_last_err", {63'd0, frame_err}, 64'd1);
    check("early_last_no_out", {63'd0, m_valid}, 64'd0);
    send_vec(8'h80, 8'h10);
    check("early_recover_addr", m_address, V_RAMP);
    tick();
    check("early_recover_count", 64'(outq.size()), 64'd1);

    // Missing s_last: 16 unterminated beats then 3 more, all dropped.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared_by_rst", {63'd0, frame_err}, 64'd0);
    outq.delete();
    for (int i = 0; i < 16; i++) beat(8'h7F, 1'b0);
    check("missing_last_err", {63'd0, frame_err}, 64'd1);
    check("drop_s_ready", {63'd0, s_ready}, 64'd1);
    for (int i = 0; i < 3; i++) beat(8'h7F, i == 2);
    tick();
    check("drop_no_out", 64'(outq.size()), 64'd0);
    check("drop_no_valid", {63'd0, m_valid}, 64'd0);
    send_vec(8'h00, 8'h00);
    check("drop_recover_addr", m_address, V_ZERO);
    check("drop_err_sticky", {63'd0, frame_err}, 64'd1);
    tick();

    // Reset mid-vector with a held output.
    outq.delete();
    m_ready = 1'b0;
    send_vec(8'h00, 8'h00);
    for (int i = 0; i < 8; i++) beat(8'h7F, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid_low", {63'd0, m_valid}, 64'd0);
    check("midrst_s_ready_low", {63'd0, s_ready}, 64'd0);
    tick();
    check("midrst_addr_clear", m_address, 64'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    send_vec(8'h80, 8'h10);
    check("midrst_repack", m_address, V_RAMP);
    tick();
    check("midrst_count", 64'(outq.size()), 64'd1);
    check("midrst_only_new", outq.size() > 0 ? outq[0] : 'x, V_RAMP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
